des10_align: RTL and testbench



---
 rtl/des10_align.sv | 161 ++++++++++++++++
 tb/tb_des10_align.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/des10_align.sv
// des10_align -- fabric 1:10 deserializer with word alignment.
//
// Samples one serial bit per rising clk edge and assembles 10-bit words
// LSB-first: q[0] is the oldest bit of the word, which matches OSER10's
// D0-first ordering. Word boundaries are moved one bit later per slip,
// either on a manual bitslip pulse (IDLE only) or automatically while
// searching for ALIGN_PATTERN after a rising edge of align_en.
//
// Ports:
//   clk         sampling clock, one serial bit per rising edge
//   rst_i       asynchronous active-low reset
//   din         serial data
//   bitslip     manual slip request, single-cycle pulse, honoured in IDLE
//   align_en    level; a rising edge starts automatic alignment
//   q           deserialized word (q[0] = first bit received)
//   q_valid     one-cycle strobe, high in the cycle q updates
//   pclk_o      divided word clock, period 10 clk (11 across a slip)
//   locked      alignment achieved
//   slip_count  total slips applied, mod 10

module des10_align #(
    parameter logic [9:0] ALIGN_PATTERN = 10'b0000011111,
    parameter int         LOCK_COUNT    = 4,
    parameter int         SLIP_HOLDOFF  = 2
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       din,
    input  logic       bitslip,
    input  logic       align_en,
    output logic [9:0] q,
    output logic       q_valid,
    output logic       pclk_o,
    output logic       locked,
    output logic [3:0] slip_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [2:0] HOLD_LAST = 3'(SLIP_HOLDOFF - 1);

    logic       din_r;
    logic [9:0] sr;
    logic [3:0] bcnt;
    logic       slip_pend;   // high for exactly the hold cycle of a slip
    logic       align_d;
    logic       align_rise;
    logic [1:0] state;
    logic [3:0] match_cnt;
    logic [2:0] hold_cnt;

    assign align_rise = align_en & ~align_d;

    // Datapath: input register, shift register, bit counter, word emission.
    // The shift register never stops; freezing only the bit counter for one
    // cycle is what pushes the next word boundary one bit later.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            din_r      <= 1'b0;
            sr         <= '0;
            bcnt       <= '0;
            q          <= '0;
            q_valid    <= 1'b0;
            pclk_o     <= 1'b0;
            slip_count <= '0;
        end else begin
            din_r  <= din;
            sr     <= {din_r, sr[9:1]};
            pclk_o <= (bcnt <= 4'd4);
            if (slip_pend) begin
                // Hold cycle: counter frozen, no emission even at bcnt==9.
                q_valid    <= 1'b0;
                slip_count <= (slip_count == 4'd9) ? 4'd0 : slip_count + 4'd1;
            end else if (bcnt == 4'd9) begin
                bcnt    <= '0;
                q       <= {din_r, sr[9:1]};
                q_valid <= 1'b1;
            end else begin
                bcnt    <= bcnt + 4'd1;
                q_valid <= 1'b0;
            end
        end
    end

    // Alignment state machine. align_d resets high so that align_en already
    // high when reset releases is not mistaken for a new request.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            locked    <= 1'b0;
            match_cnt <= '0;
            hold_cnt  <= '0;
            slip_pend <= 1'b0;
            align_d   <= 1'b1;
        end else begin
            align_d   <= align_en;
            slip_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bitslip) begin
                        slip_pend <= 1'b1;
                        locked    <= 1'b0;
                    end
                    if (align_rise) begin
                        state     <= ST_SEARCH;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (!align_en) begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end else if (q_valid) begin
                        if (q == ALIGN_PATTERN) begin
                            if (match_cnt == LOCK_LAST) begin
                                state     <= ST_LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end else begin
                            slip_pend <= 1'b1;
                            match_cnt <= '0;
                            hold_cnt  <= '0;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Skip words that may straddle the moved boundary.
                    if (!align_en) begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end else if (q_valid) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state <= ST_SEARCH;
                        end else begin
                            hold_cnt <= hold_cnt + 3'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Alignment frozen; locked survives the drop of align_en.
                    if (!align_en) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des10_align.sv
// Directed bench for des10_align: reset behaviour, manual slip, automatic
// lock, lock retention, hold-cycle emission spacing, reset during search.
module tb_des10_align;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       din;
    logic       bitslip;
    logic       align_en;
    logic [9:0] q;
    logic       q_valid;
    logic       pclk_o;
    logic       locked;
    logic [3:0] slip_count;

    always #5 clk = ~clk;

    des10_align dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .din        (din),
        .bitslip    (bitslip),
        .align_en   (align_en),
        .q          (q),
        .q_valid    (q_valid),
        .pclk_o     (pclk_o),
        .locked     (locked),
        .slip_count (slip_count)
    );

    int         checks = 0;
    int         errors = 0;
    int         ecnt   = 0;   // edges since reset release
    int         k      = 0;   // stream phase: k further slips short of 10 align it
    bit         rnd    = 0;
    logic [9:0] pat    = 10'b0000011111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // din for the next edge: periodic pattern whose bit for edge e is pat[(e+k)%10],
    // so the unslipped word is pat rotated right by k.
    task automatic drive_din();
        if (rnd) din = 1'($urandom_range(0, 1));
        else     din = pat[(ecnt + 1 + k) % 10];
    endtask

    task automatic step();
        @(posedge clk);
        ecnt++;
        #1;
        drive_din();
    endtask

    task automatic release_rst();
        rst_i = 1'b1;
        ecnt  = 0;
        drive_din();
    endtask

    task automatic reset_hold();
        rst_i = 1'b0;
        repeat (3) step();
        release_rst();
    endtask

    task automatic wait_qv(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!seen) begin
                step();
                seen = q_valid;
            end
        end
    endtask

    int first, perr, nbetween, plow;
    bit got20, got31, got41, seen;

    initial begin
        rst_i = 1'b0; din = 1'b0; bitslip = 1'b0; align_en = 1'b0;
        repeat (3) step();

        // Reset defaults: assert mid-stream, outputs clear at once.
        k = 0;
        release_rst();
        repeat (25) step();
        check("pre_rst_q", q, 10'h01F);
        rst_i = 1'b0;
        #1;
        check("rst_q", q, 0);
        check("rst_qv", q_valid, 0);
        check("rst_pclk", pclk_o, 0);
        check("rst_locked", locked, 0);
        check("rst_slips", slip_count, 0);
        repeat (2) step();
        release_rst();
        first = -1; perr = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (q_valid && first < 0) first = e;
            if (pclk_o !== (((e - 1) % 10) <= 4)) perr++;
        end
        check("first_qv_edge", first, 10);
        check("pclk_shape_errs", perr, 0);

        // Manual slip from offset 3: seven slips align the word.
        k = 3;
        reset_hold();
        repeat (15) step();
        for (int n = 0; n < 7; n++) begin
            bitslip = 1'b1;
            step();
            bitslip = 1'b0;
            repeat (12) step();
        end
        wait_qv(seen);
        check("man_qv_seen", seen, 1);
        check("man_q", q, 10'h01F);
        check("man_slips", slip_count, 7);
        check("man_locked", locked, 0);

        // Auto-lock from offset 6: four slips, then four matches.
        k = 6;
        reset_hold();
        repeat (5) step();
        align_en = 1'b1;
        for (int i = 0; i < 600; i++) if (!locked) step();
        check("auto_locked", locked, 1);
        check("auto_slips", slip_count, 4);
        for (int n = 0; n < 3; n++) begin
            wait_qv(seen);
            check("auto_qv_seen", seen, 1);
            check("auto_q", q, 10'h01F);
        end

        // Lock retention under random data and align_en toggling.
        rnd = 1;
        repeat (60) step();
        check("ret_locked", locked, 1);
        check("ret_slips", slip_count, 4);
        align_en = 1'b0;
        repeat (5) step();
        check("ret_locked_idle", locked, 1);
        align_en = 1'b1;
        repeat (2) step();
        check("ret_relock_clr", locked, 0);
        rnd = 0;
        align_en = 1'b0;

        // Hold cycle landing on bcnt==9: strobes at 20, 31, 41.
        k = 0;
        reset_hold();
        nbetween = 0; plow = 0; got20 = 0; got31 = 0; got41 = 0;
        for (int e = 1; e <= 45; e++) begin
            step();
            bitslip = (e == 28);
            if (q_valid) begin
                if (e > 20 && e <= 40) nbetween++;
                if (e == 20) got20 = 1;
                if (e == 31) got31 = 1;
                if (e == 41) got41 = 1;
            end
            if (e >= 21 && e <= 35 && !pclk_o) plow++;
        end
        bitslip = 1'b0;
        check("hold_qv20", got20, 1);
        check("hold_qv31", got31, 1);
        check("hold_qv41", got41, 1);
        check("hold_qv_count", nbetween, 1);
        check("hold_pclk_low", plow, 6);
        check("hold_slips", slip_count, 1);

        // Reset while in HOLD; align_en left high must not restart search.
        k = 6;
        reset_hold();
        repeat (3) step();
        align_en = 1'b1;
        for (int i = 0; i < 200; i++) if (slip_count != 4'd1) step();
        check("ms_first_slip", slip_count, 1);
        repeat (3) step();
        rst_i = 1'b0;
        #1;
        check("ms_rst_slips", slip_count, 0);
        check("ms_rst_locked", locked, 0);
        repeat (2) step();
        release_rst();
        repeat (100) step();
        check("ms_idle_slips", slip_count, 0);
        check("ms_idle_locked", locked, 0);
        align_en = 1'b0;
        repeat (2) step();
        align_en = 1'b1;
        for (int i = 0; i < 600; i++) if (!locked) step();
        check("ms_relock", locked, 1);
        check("ms_relock_slips", slip_count, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
